// File: rtl/gr8b0nd_ctrl.sv
// rtl/gr8b0nd_ctrl.sv - gr8b0nd multicycle fetch/decode/execute sequencer
// Owns PC, IR and the 16x16 register file; ALU operations are delegated to an external ALU.
module gr8b0nd_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [7:0]  alu_sel,
    input  logic [15:0] alu_out,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] pc
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_regs [16];
    logic        r_illegal;

    logic [3:0]  w_op4;
    logic [7:0]  w_op8;
    logic [7:0]  w_imm8;
    logic [3:0]  w_rs;
    logic [3:0]  w_rd;
    logic [15:0] w_src;
    logic [15:0] w_dst;
    logic [15:0] w_simm;
    logic        w_is_imm;
    logic        w_is_alu;
    logic        w_legal8;
    logic        w_is_trap;
    logic        w_is_bad;
    logic        w_is_mem;
    logic        w_is_st;

    logic        w_wb_en;
    logic [15:0] w_wb_data;
    logic        w_pc_load;
    logic [15:0] w_pc_next;

    assign w_op4    = r_ir[15:12];
    assign w_op8    = r_ir[15:8];
    assign w_imm8   = r_ir[11:4];
    assign w_rs     = r_ir[7:4];
    assign w_rd     = r_ir[3:0];
    assign w_src    = r_regs[w_rs];
    assign w_dst    = r_regs[w_rd];
    assign w_simm   = {{8{w_imm8[7]}}, w_imm8};
    assign w_is_imm = (w_op4 >= 4'hb);

    assign w_is_alu = w_op8 inside {8'h10, 8'h32, 8'h33, [8'h50:8'h52], [8'h60:8'h63], [8'h70:8'h77]};
    assign w_legal8 = w_is_alu || (w_op8 inside {8'h00, 8'h01, 8'h30, 8'h31, 8'h40, 8'h41});
    assign w_is_trap = !w_is_imm && (w_op8 == 8'h00);
    assign w_is_bad  = !w_is_imm && !w_legal8;
    assign w_is_mem  = !w_is_imm && (w_op8 == 8'h40 || w_op8 == 8'h41);
    assign w_is_st   = !w_is_imm && (w_op8 == 8'h41);

    // Result of the EXEC step: either a register writeback or a PC redirect.
    // PC already points past the branch, so PCbr + 1 + simm == r_pc + simm.
    always_comb begin
        w_wb_en   = 1'b0;
        w_wb_data = alu_out;
        w_pc_load = 1'b0;
        w_pc_next = r_pc + w_simm;
        if (w_is_imm) begin
            case (w_op4)
                4'hb: begin w_wb_en = 1'b1; w_wb_data = w_simm; end
                4'hc: begin w_wb_en = 1'b1; w_wb_data = {w_imm8, w_imm8}; end
                4'hd: begin w_wb_en = 1'b1; w_wb_data = {w_imm8, w_dst[7:0]}; end
                4'he: w_pc_load = (w_dst == 16'h0000);
                4'hf: w_pc_load = (w_dst != 16'h0000);
                default: ;
            endcase
        end else if (w_is_alu) begin
            w_wb_en = 1'b1;
        end else begin
            case (w_op8)
                8'h30: begin w_wb_en = 1'b1; w_wb_data = {15'h0000, |w_dst}; end
                8'h31: begin
                    w_wb_en   = 1'b1;
                    w_wb_data = {7'h00, |w_dst[15:8], 7'h00, |w_dst[7:0]};
                end
                8'h01: begin w_pc_load = 1'b1; w_pc_next = w_dst; end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ack) w_next = S_DECODE;
            S_DECODE: w_next = (w_is_trap || w_is_bad) ? S_HALT : S_EXEC;
            S_EXEC:   w_next = w_is_mem ? S_MEM : S_FETCH;
            S_MEM:    if (mem_ack) w_next = S_FETCH;
            default:  w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= 16'h0000;
            r_ir      <= 16'h0000;
            r_illegal <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: begin
                    if (mem_ack) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + 16'h0001;
                    end
                end
                S_DECODE: begin
                    if (w_is_bad) r_illegal <= 1'b1;
                end
                S_EXEC: begin
                    if (w_wb_en) r_regs[w_rd] <= w_wb_data;
                    if (w_pc_load) r_pc <= w_pc_next;
                end
                S_MEM: begin
                    if (mem_ack && !w_is_st) r_regs[w_rd] <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // rst_n gates the request so it is low while reset is held even though state is FETCH.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = r_pc;
        mem_wdata = 16'h0000;
        case (r_state)
            S_FETCH: mem_req = rst_n;
            S_MEM: begin
                mem_req   = rst_n;
                mem_we    = w_is_st;
                mem_addr  = w_src;
                mem_wdata = w_dst;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_a   = 16'h0000;
        alu_b   = 16'h0000;
        alu_sel = 8'h00;
        if (r_state != S_HALT) begin
            alu_a   = w_src;
            alu_b   = w_dst;
            alu_sel = w_op8;
        end
    end

    assign halted  = (r_state == S_HALT);
    assign illegal = r_illegal;
    assign pc      = r_pc;

endmodule

// File: tb/tb_gr8b0nd_ctrl.sv
// tb/tb_gr8b0nd_ctrl.sv - directed self-checking bench for gr8b0nd_ctrl
module tb_gr8b0nd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [7:0]  alu_sel;
    logic [15:0] alu_out;
    logic        halted;
    logic        illegal;
    logic [15:0] pc;

    logic [15:0] mem [256];
    int          ack_delay = 0;
    int          req_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    gr8b0nd_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .halted    (halted),
        .illegal   (illegal),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    assign mem_ack   = mem_req && (req_cnt >= ack_delay);
    assign mem_rdata = mem[mem_addr[7:0]];
    assign alu_out   = (alu_sel == 8'h70) ? (alu_a + alu_b) : (alu_a ^ alu_b);

    always @(posedge clk) begin
        if (mem_req && !mem_ack) req_cnt <= req_cnt + 1;
        else                     req_cnt <= 0;
        if (mem_req && mem_ack && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic start_reset();
        rst_n     = 1'b0;
        ack_delay = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0000", mem_addr); end
        checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL rst_halt got=%b%b exp=00", halted, illegal); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rst_pc got=%h exp=0000", pc); end
        checks++; if (alu_sel !== 8'h00 || alu_a !== 16'h0000 || alu_b !== 16'h0000) begin
            errors++; $display("FAIL rst_alu got=%h/%h/%h exp=00/0000/0000", alu_sel, alu_a, alu_b); end
        checks++; if (mem_we !== 1'b0 || mem_wdata !== 16'h0000) begin errors++; $display("FAIL rst_we_wdata got=%b/%h exp=0/0000", mem_we, mem_wdata); end
        release_reset();
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++; $display("FAIL rst_first_req got=%b/%h exp=1/0000", mem_req, mem_addr); end
    endtask

    task automatic test_alu();
        start_reset();
        mem[0] = 16'hBFE1;
        mem[1] = 16'hB032;
        mem[2] = 16'h7012;
        release_reset();
        cyc(8);
        checks++; if (dut.r_regs[1] !== 16'hFFFE) begin errors++; $display("FAIL alu_r1 got=%h exp=fffe", dut.r_regs[1]); end
        checks++; if (dut.r_regs[2] !== 16'h0003) begin errors++; $display("FAIL alu_r2 got=%h exp=0003", dut.r_regs[2]); end
        checks++; if (alu_sel !== 8'h70 || alu_a !== 16'hFFFE || alu_b !== 16'h0003) begin
            errors++; $display("FAIL alu_operands got=%h/%h/%h exp=70/fffe/0003", alu_sel, alu_a, alu_b); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL alu_exec_req got=%b exp=0", mem_req); end
        cyc(1);
        checks++; if (dut.r_regs[2] !== 16'h0001) begin errors++; $display("FAIL alu_wb got=%h exp=0001", dut.r_regs[2]); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0003) begin
            errors++; $display("FAIL alu_fetch3 got=%b/%h exp=1/0003", mem_req, mem_addr); end
    endtask

    task automatic test_const();
        start_reset();
        mem[0] = 16'hC5A3;
        mem[1] = 16'hD123;
        release_reset();
        cyc(3);
        checks++; if (dut.r_regs[3] !== 16'h5A5A) begin errors++; $display("FAIL cii got=%h exp=5a5a", dut.r_regs[3]); end
        cyc(3);
        checks++; if (dut.r_regs[3] !== 16'h125A) begin errors++; $display("FAIL cup got=%h exp=125a", dut.r_regs[3]); end
    endtask

    task automatic test_branch(input logic [15:0] first, input logic [15:0] exp_addr);
        start_reset();
        mem[0] = first;
        for (int i = 1; i < 5; i++) mem[i] = 16'hB000;
        mem[5] = 16'hE024;
        release_reset();
        cyc(15);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0005) begin
            errors++; $display("FAIL br_fetch5 got=%b/%h exp=1/0005", mem_req, mem_addr); end
        cyc(3);
        checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
            errors++; $display("FAIL br_target got=%b/%h exp=1/%h", mem_req, mem_addr, exp_addr); end
    endtask

    task automatic test_ldst();
        int st_cnt = 0;
        int ld_cnt = 0;
        int bad_wdata = 0;
        start_reset();
        mem[0] = 16'hB405;
        mem[1] = 16'hB9A6;
        mem[2] = 16'h4156;
        mem[3] = 16'h4057;
        ack_delay = 3;
        release_reset();
        for (int i = 0; i < 200 && !halted; i++) begin
            cyc(1);
            if (mem_req && mem_addr == 16'h0040) begin
                if (mem_we) begin
                    st_cnt++;
                    if (mem_wdata !== 16'hFF9A) bad_wdata++;
                end else begin
                    ld_cnt++;
                end
            end
        end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ldst_timeout got=%b exp=1", halted); end
        checks++; if (st_cnt != 4) begin errors++; $display("FAIL st_hold got=%0d exp=4", st_cnt); end
        checks++; if (ld_cnt != 4) begin errors++; $display("FAIL ld_hold got=%0d exp=4", ld_cnt); end
        checks++; if (bad_wdata != 0) begin errors++; $display("FAIL st_wdata_stable got=%0d bad cycles exp=0", bad_wdata); end
        checks++; if (mem[8'h40] !== 16'hFF9A) begin errors++; $display("FAIL st_mem got=%h exp=ff9a", mem[8'h40]); end
        checks++; if (dut.r_regs[7] !== 16'hFF9A) begin errors++; $display("FAIL ld_r7 got=%h exp=ff9a", dut.r_regs[7]); end
    endtask

    task automatic test_trap();
        int req_seen = 0;
        start_reset();
        mem[0] = 16'h0000;
        release_reset();
        cyc(1);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL trap_early got=%b exp=0", halted); end
        cyc(1);
        checks++; if (halted !== 1'b1 || illegal !== 1'b0) begin
            errors++; $display("FAIL trap_flags got=%b%b exp=10", halted, illegal); end
        checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL trap_pc got=%h exp=0001", pc); end
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (mem_req !== 1'b0) req_seen++;
        end
        checks++; if (req_seen != 0) begin errors++; $display("FAIL trap_quiet got=%0d req cycles exp=0", req_seen); end
        checks++; if (pc !== 16'h0001 || halted !== 1'b1) begin
            errors++; $display("FAIL trap_hold got=%h/%b exp=0001/1", pc, halted); end
    endtask

    task automatic test_illegal();
        start_reset();
        mem[0] = 16'h2000;
        release_reset();
        cyc(2);
        checks++; if (illegal !== 1'b1 || halted !== 1'b1) begin
            errors++; $display("FAIL illegal_flags got=%b%b exp=11", halted, illegal); end
        checks++; if (alu_sel !== 8'h00) begin errors++; $display("FAIL illegal_alu_sel got=%h exp=00", alu_sel); end
    endtask

    task automatic test_async_reset();
        start_reset();
        mem[0] = 16'hB0FE;
        mem[1] = 16'hB0FE;
        release_reset();
        cyc(3);
        ack_delay = 10;
        cyc(1);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin
            errors++; $display("FAIL ar_stall got=%b/%h exp=1/0001", mem_req, mem_addr); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0000) begin
            errors++; $display("FAIL ar_mem got=%b/%h exp=0/0000", mem_req, mem_addr); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL ar_pc got=%h exp=0000", pc); end
        checks++; if (alu_sel !== 8'h00 || alu_b !== 16'h0000) begin
            errors++; $display("FAIL ar_alu got=%h/%h exp=00/0000", alu_sel, alu_b); end
        checks++; if (dut.r_regs[0] !== 16'h0000) begin errors++; $display("FAIL ar_regs got=%h exp=0000", dut.r_regs[0]); end
        ack_delay = 0;
        release_reset();
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++; $display("FAIL ar_restart got=%b/%h exp=1/0000", mem_req, mem_addr); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_const();
        test_branch(16'hB004, 16'h0008);
        test_branch(16'hB014, 16'h0006);
        test_ldst();
        test_trap();
        test_illegal();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gr8b0nd_ctrl.md
# gr8b0nd_ctrl

Multicycle control and datapath sequencer for the gr8b0nd 16-bit processor. It sits directly upstream of the ALU. It fetches instructions from a single-port memory, decodes them, and owns the PC, instruction register and 16×16 register file. For ALU operations it drives the ALU operands and 8-bit select, then writes the ALU result back. Constants, branches, jr, ld/st and trap are executed without the ALU.

## Interface
- No parameters: word width 16, 16 registers, 16-bit word address space.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- mem_req  out  1  memory request; held high until accepted
- mem_we  out  1  1 = store, 0 = read (fetch or ld)
- mem_addr  out  16  word address
- mem_wdata  out  16  store data
- mem_ack  in  1  accepts the request on this edge; mem_rdata valid in this cycle
- mem_rdata  in  16  read data
- alu_a  out  16  ALU source operand, R[rs]
- alu_b  out  16  ALU destination operand, R[rd]
- alu_sel  out  8  ALU select, equal to the 8-bit opcode
- alu_out  in  16  combinational ALU result
- halted  out  1  processor stopped
- illegal  out  1  stopped on an undefined opcode
- pc  out  16  current PC (debug)

## Operation
- **Decode**
  - If ir[15:12] ≥ 4'hb: op4 = ir[15:12], imm8 = ir[11:4], rd = ir[3:0].
  - Otherwise: op8 = ir[15:8], rs = ir[7:4], rd = ir[3:0].
- **ci8 (b):** R[rd] = sign-extend(imm8).
- **cii (c):** R[rd] = {imm8, imm8}.
- **cup (d):** R[rd][15:8] = imm8; low byte unchanged.
- **bz (e) / bnz (f):** if R[rd] == 0 (bz) or R[rd] != 0 (bnz), PC = PCbr + 1 + sign-extend(imm8). PCbr is the branch's own address. All arithmetic is mod 2^16.
- **ALU ops** (0x10, 0x32, 0x33, 0x50–0x52, 0x60–0x63, 0x70–0x77): alu_a = R[rs], alu_b = R[rd], alu_sel = op8; R[rd] = alu_out.
- **anyi (0x30):** R[rd] = (R[rd] != 0).
- **anyii (0x31):** each byte of R[rd] = (that byte != 0).
- **ld (0x40):** R[rd] = mem[R[rs]].
- **st (0x41):** mem[R[rs]] = R[rd].
- **jr (0x01):** PC = R[rd].
- **trap (0x00):** halted = 1.
- **Any other opcode:** illegal = 1 and halted = 1. This includes 0x20–0x25.
- **State machine:** FETCH → DECODE → EXEC → (MEM for ld/st) → FETCH. HALT is terminal until reset.
  - FETCH: mem_req = 1, mem_we = 0, mem_addr = PC. On mem_ack: IR = mem_rdata, PC = PC + 1 (wraps FFFF → 0000), go to DECODE.
  - DECODE: registers read; op classified. Trap and illegal go to HALT.
  - EXEC: register writeback or PC update. ld/st go to MEM.
  - MEM: mem_req = 1, mem_addr = R[rs], mem_we = (st), mem_wdata = R[rd]. On mem_ack, ld writes R[rd]; go to FETCH.
- Outputs are stable for the whole time mem_req is high. mem_ack is ignored when mem_req = 0.
- alu_a, alu_b and alu_sel are driven from the decoded IR in every state except HALT. alu_out is sampled only at the EXEC edge.

## Timing
- **Reset (asynchronous, immediate):**
  - State = FETCH, PC = 0, IR = 0, all registers = 0.
  - mem_req = 0 during reset; asserted in the first cycle after deassertion.
  - halted = 0, illegal = 0, alu_sel = 0, alu_a = 0, alu_b = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Reset during FETCH or MEM abandons the transaction; nothing is written.
- **Cycles per instruction, zero-wait memory** (mem_ack in the same cycle as mem_req):
  - ALU, constant, branch and jr: 3 cycles.
  - ld/st: 4 cycles.
  - Each wait cycle adds 1 to FETCH or MEM.
- **Register writeback** takes effect at the EXEC edge (ld: the MEM ack edge), so it is visible to the next instruction.
- **HALT:**
  - mem_req = 0 and no register or PC changes.
  - halted and illegal are asserted from the DECODE edge onward.
  - pc holds the address after the trap/illegal word.
- Same-register source/destination (rs == rd) reads the old value.

## Test plan
- Memory 0: B FE 1, B 03 2, 7012 (ci8 r1,-2; ci8 r2,3; addi). Required:
  - r1 = FFFE, r2 = 0003.
  - During the third instruction's EXEC: alu_sel = 70, alu_a = FFFE, alu_b = 0003.
  - r2 = alu_out. Fetch of address 3 starts at cycle 9.
- C5A3 then D123. Required: r3 = 5A5A, then r3 = 125A.
- At address 5 with r4 = 0: E024 (bz r4,+2). Required: next fetch address = 0008. With r4 = 1, the next fetch address is 0006.
- st 0x4156 (mem[R5] = R6) then ld 0x4057, with mem_ack delayed 3 cycles. Required:
  - mem_req held for 4 cycles each, with mem_addr and mem_wdata stable throughout.
  - r7 = old r6.
- 0x0000 fetched. Required: halted = 1, illegal = 0, mem_req stays 0 for 20 cycles. Separately, 0x2000 fetched: illegal = 1, halted = 1.
- rst_n pulled low mid-FETCH while mem_ack is low. Required: all outputs reset asynchronously, and the first request after release has mem_addr = 0000.
